// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch requester with in-order response queue and redirect flush
module ifu_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(QUEUE_DEPTH);

    logic [31:0] pc, rsp_pc, pc_n, target;
    logic        req_stale, accept, hold, pop, push, raise;
    logic [CW-1:0] inflight, drop_cnt, count, inflight_rsp, count_n;
    logic [AW-1:0] head, tail;
    logic [31:0] q_pc [QUEUE_DEPTH];
    logic [31:0] q_data [QUEUE_DEPTH];

    assign inst_valid = count != '0;
    assign inst_pc    = q_pc[head];
    assign inst_data  = q_data[head];

    // Next-state terms; a stale (pre-redirect) request must not advance the new-stream pc
    always_comb begin
        target       = redirect_pc & ~32'd3;
        accept       = imem_req_valid && imem_req_ready;
        hold         = imem_req_valid && !imem_req_ready;
        pop          = inst_valid && inst_ready;
        push         = imem_rsp_valid && !redirect_valid && drop_cnt == '0;
        pc_n         = redirect_valid ? target : (accept && !req_stale) ? pc + 32'd4 : pc;
        inflight_rsp = inflight - CW'(imem_rsp_valid);
        count_n      = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        raise        = !hold && !redirect_valid && ({1'b0, inflight_rsp} + {1'b0, count_n} < DEPTH);
    end

    // Fetch state, request channel, drop accounting and instruction queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            rsp_pc         <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            req_stale      <= 1'b0;
            inflight       <= '0;
            drop_cnt       <= '0;
            count          <= '0;
            head           <= '0;
            tail           <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else begin
            pc             <= pc_n;
            rsp_pc         <= redirect_valid ? target : push ? rsp_pc + 32'd4 : rsp_pc;
            imem_req_valid <= hold || raise;
            if (raise)
                imem_req_addr <= pc_n;
            req_stale      <= hold && (req_stale || redirect_valid);
            inflight       <= inflight_rsp + CW'(raise);
            drop_cnt       <= redirect_valid ? inflight_rsp :
                              (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
            count          <= count_n;
            head           <= redirect_valid ? '0 : head + AW'(pop);
            tail           <= redirect_valid ? '0 : tail + AW'(push);
            if (push) begin
                q_pc[tail]   <= rsp_pc;
                q_data[tail] <= imem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized bench for ifu_fetch against an in-order memory and program-order model
module tb_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_ready = 1'b0;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst_pc, inst_data;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int lat = 1;
    int n_deliv = 0;
    int n = 0;
    logic [31:0] exp_pc = RST_PC;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;
    req_t mem_q [$];

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data)
    );

    always #5 clk = ~clk;

    // Memory contents: program word i at RST_PC+4i is 0x13+i
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h13 + ((a - RST_PC) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    // One clock: log handshakes that happen at the edge, then drive the memory response
    task automatic cycle();
        logic        hold;
        logic [31:0] held;
        req_t        r;
        hold = imem_req_valid && !imem_req_ready;
        held = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            r.addr = imem_req_addr;
            r.rdy  = cyc + lat;
            mem_q.push_back(r);
        end
        if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, word_at(exp_pc));
            exp_pc += 32'd4;
            n_deliv++;
        end
        if (redirect_valid)
            exp_pc = redirect_pc & ~32'd3;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (hold) begin
            chk1("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", imem_req_addr, held);
        end
        if (mem_q.size() != 0 && mem_q[0].rdy <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        @(posedge clk);
        #1;
        mem_q.delete();
        exp_pc = RST_PC;
        rst_n  = 1'b1;
    endtask

    task automatic wait_inst(input int budget);
        for (int k = 0; k < budget && !inst_valid; k++)
            cycle();
        chk1("wait_inst", inst_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            redirect_valid = 1'($urandom);
            redirect_pc    = $urandom;
            imem_req_ready = 1'($urandom);
            imem_rsp_valid = 1'($urandom);
            imem_rsp_data  = $urandom;
            inst_ready     = 1'($urandom);
            @(posedge clk);
            #1;
            chk1("inrst_req_valid", imem_req_valid, 1'b0);
            chk1("inrst_inst_valid", inst_valid, 1'b0);
        end
        do_reset();

        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        cycle();
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        cycle();
        chk1("lat_n1_inst_valid", inst_valid, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            chk1("stream_valid", inst_valid, 1'b1);
            chk("stream_pc", inst_pc, RST_PC + 32'(4 * i));
            chk("stream_data", inst_data, 32'h13 + 32'(i));
            cycle();
        end

        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (10) cycle();
        chk1("bp_inst_valid", inst_valid, 1'b1);
        chk("bp_head_pc", inst_pc, RST_PC);
        chk1("bp_req_idle", imem_req_valid, 1'b0);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        n = 0;
        for (int k = 0; k < 10 && inst_valid; k++) begin
            cycle();
            n++;
        end
        chk("bp_drain_count", 32'(n), 32'd4);
        chk1("bp_drained", inst_valid, 1'b0);
        chk1("resume_valid", imem_req_valid, 1'b1);
        chk("resume_addr", imem_req_addr, RST_PC + 32'h10);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk1("stall_valid", imem_req_valid, 1'b1);
            chk("stall_addr", imem_req_addr, RST_PC + 32'h10);
        end
        imem_req_ready = 1'b1;
        cycle();
        chk1("b2b_valid", imem_req_valid, 1'b1);
        chk("b2b_addr", imem_req_addr, RST_PC + 32'h14);

        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 3;
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        cycle();
        chk1("redir_flush", inst_valid, 1'b0);
        wait_inst(20);
        chk("redir_pc0", inst_pc, 32'h8000_0100);
        cycle();
        wait_inst(20);
        chk("redir_pc1", inst_pc, 32'h8000_0104);

        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        wait_inst(20);
        chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        cycle();
        wait_inst(20);
        chk("wrap_pc1", inst_pc, 32'h0);

        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        repeat (5) cycle();
        chk1("coll_pre_inst", inst_valid, 1'b1);
        chk1("coll_pre_req", imem_req_valid, 1'b1);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h9000_0006;
        n = n_deliv;
        cycle();
        chk("coll_consumed", 32'(n_deliv - n), 32'd1);
        chk1("coll_flush", inst_valid, 1'b0);
        repeat (2) cycle();
        chk1("coll_no_leak", inst_valid, 1'b0);
        imem_req_ready = 1'b1;
        wait_inst(20);
        chk("coll_new_pc", inst_pc, 32'h9000_0004);

        do_reset();
        n = n_deliv;
        for (int i = 0; i < 2000; i++) begin
            imem_req_ready = $urandom_range(0, 3) != 0;
            inst_ready     = $urandom_range(0, 9) < 7;
            lat            = $urandom_range(1, 4);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            cycle();
        end
        chk1("rand_progress", (n_deliv - n) > 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
